// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/stop engine sequencing CPU reset, execution enable and cycle budget
//
// Purpose:
//   Holds the CPU in reset for RST_CYCLES after a start request, then enables
//   the CPU and counts enabled cycles. A run ends on halt_req (done) or when
//   the count reaches MAX_CYCLES (timeout); halt wins if both occur together.
//   All outputs are registered.
//
// Optional feature (macro CPU_RUN_STEP_EN):
//   Adds step_mode/step inputs. With step_mode=1 the CPU is enabled for one
//   cycle per rising edge of the registered step input while in RUN.
//
// Ports:
//   clk        in   1      system clock
//   rst        in   1      asynchronous active-high reset
//   start      in   1      begin a new run (sampled in IDLE/DONE/TIMEOUT)
//   halt_req   in   1      CPU halt indication (RUN, enabled cycles only)
//   step_mode  in   1      single-step select (CPU_RUN_STEP_EN only)
//   step       in   1      single-step request (CPU_RUN_STEP_EN only)
//   cpu_rst    out  1      reset to CPU core, active-high
//   cpu_en     out  1      clock enable to CPU core
//   cycle_cnt  out  CNT_W  enabled RUN cycles of current/last run
//   done       out  1      run ended by halt_req
//   timeout    out  1      run ended by budget exhaustion
//   busy       out  1      high in RESET and RUN

module cpu_run_ctrl #(
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
`ifdef CPU_RUN_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             done,
    output logic             timeout,
    output logic             busy
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t           r_state;
    logic [RW-1:0]    r_rst_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cpu_rst;
    logic             r_cpu_en;
    logic             r_done;
    logic             r_timeout;
    logic             r_busy;

    logic             w_entry_en;   // cpu_en value on RESET -> RUN
    logic             w_next_en;    // cpu_en value for the next RUN cycle
    logic             w_en_cycle;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_budget_hit;

`ifdef CPU_RUN_STEP_EN
    logic r_step_q;
    logic r_step_q2;
    logic w_step_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_q  <= 1'b0;
            r_step_q2 <= 1'b0;
        end else begin
            r_step_q  <= step;
            r_step_q2 <= r_step_q;
        end
    end

    assign w_step_rise = r_step_q & ~r_step_q2;
    // A step edge coinciding with RESET -> RUN is outside RUN and is dropped.
    assign w_entry_en  = ~step_mode;
    assign w_next_en   = ~step_mode | w_step_rise;
`else
    assign w_entry_en  = 1'b1;
    assign w_next_en   = 1'b1;
`endif

    // The enable is registered, so a cycle is "enabled" when cpu_en is high now.
    assign w_en_cycle   = (r_state == S_RUN) && r_cpu_en;
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_budget_hit = (w_cnt_inc == CNT_W'(MAX_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rst_cnt <= '0;
            r_cnt     <= '0;
            r_cpu_rst <= 1'b1;
            r_cpu_en  <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (start) begin
                        r_state   <= S_RESET;
                        r_rst_cnt <= '0;
                        r_cnt     <= '0;
                        r_cpu_rst <= 1'b1;
                        r_cpu_en  <= 1'b0;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_RESET: begin
                    if (r_rst_cnt == RW'(RST_CYCLES - 1)) begin
                        r_state   <= S_RUN;
                        r_cpu_rst <= 1'b0;
                        r_cpu_en  <= w_entry_en;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RW'(1);
                    end
                end
                S_RUN: begin
                    if (w_en_cycle) begin
                        r_cnt <= w_cnt_inc;
                        // Halt takes priority over budget exhaustion.
                        if (halt_req) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_cpu_en <= 1'b0;
                            r_busy   <= 1'b0;
                        end else if (w_budget_hit) begin
                            r_state   <= S_TIMEOUT;
                            r_timeout <= 1'b1;
                            r_cpu_en  <= 1'b0;
                            r_busy    <= 1'b0;
                        end else begin
                            r_cpu_en <= w_next_en;
                        end
                    end else begin
                        r_cpu_en <= w_next_en;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cpu_rst <= 1'b1;
                    r_cpu_en  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rst   = r_cpu_rst;
    assign cpu_en    = r_cpu_en;
    assign cycle_cnt = r_cnt;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign busy      = r_busy;

endmodule
